// File: rtl/kronos_data_mem_responder.sv
// Data-memory responder for the Kronos SoC data port: word-addressed SRAM,
// MMIO stop/trap/dump window at 0x00..0x1F, and a delayed sticky done flag.
module kronos_data_mem_responder #(
    parameter logic [31:0] MEM_BASE     = 32'h0000_1000,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned GNT_WAIT     = 0,
    parameter int unsigned STOP_DELAY   = 50,
    parameter bit          STOP_ON_TRAP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_mem_req,
    output logic        data_mem_gnt,
    input  logic [31:0] data_mem_addr,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  data_mem_strb,
    input  logic        data_mem_we,
    output logic [31:0] data_mem_rdata,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        dump_valid_o,
    output logic [4:0]  dump_idx_o,
    output logic [31:0] dump_data_o,
    output logic [7:0]  trap_count_o,
    output logic        done_o
);

    localparam int unsigned IDX_W         = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_END       = {1'b0, MEM_BASE} + 33'(4 * MEM_WORDS);
    localparam logic [31:0] WAIT_INIT     = 32'(GNT_WAIT) - 32'd1;
    localparam logic [31:0] STOP_CNT_INIT = 32'(STOP_DELAY);
    localparam logic [31:0] UNMAPPED_DATA = 32'hBADC_AB1E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        gnt_raw;

    logic [31:0] rdata_q, rdata_d;
    logic        resp_sram_q, resp_sram_d;
    logic        err_q, err_d;
    logic        armed_q, armed_d;
    logic [31:0] stop_cnt_q, stop_cnt_d;
    logic        done_q, done_d;
    logic [7:0]  trap_cnt_q, trap_cnt_d;
    logic        dump_valid_q, dump_valid_d;
    logic [4:0]  dump_idx_q, dump_idx_d;
    logic [31:0] dump_data_q, dump_data_d;

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] mem_rdata_q;

    logic             accept;
    logic             mmio_hit;
    logic             sram_hit;
    logic [2:0]       mmio_sel;
    logic [31:0]      sram_off;
    logic [IDX_W-1:0] mem_idx;
    logic             strb_any;
    logic             arm_req;
    logic             mem_we;
    logic             unused_sram_off;

    assign accept   = data_mem_req & data_mem_gnt;
    assign mmio_hit = (data_mem_addr[31:5] == 27'd0);
    assign mmio_sel = data_mem_addr[4:2];
    assign sram_hit = ({1'b0, data_mem_addr} >= {1'b0, MEM_BASE}) &&
                      ({1'b0, data_mem_addr} < MEM_END);
    assign sram_off = data_mem_addr - MEM_BASE;
    assign mem_idx  = sram_off[IDX_W+1:2];
    assign strb_any = |data_mem_strb;
    assign unused_sram_off = &{1'b0, sram_off[31:IDX_W+2], sram_off[1:0]};

    // Handshake FSM; WAIT holds the request for GNT_WAIT cycles before granting.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gnt_raw    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (data_mem_req) begin
                    if (GNT_WAIT == 0) begin
                        gnt_raw = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_cnt_d = WAIT_INIT;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!data_mem_req) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == '0) begin
                    gnt_raw = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 32'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: grant is masked by reset so a request held through reset is never accepted.
    assign data_mem_gnt = gnt_raw & rst_ni;

    always_comb begin
        rdata_d      = rdata_q;
        resp_sram_d  = 1'b0;
        err_d        = 1'b0;
        trap_cnt_d   = trap_cnt_q;
        dump_valid_d = 1'b0;
        dump_data_d  = dump_data_q;
        dump_idx_d   = dump_idx_q;
        armed_d      = armed_q;
        stop_cnt_d   = stop_cnt_q;
        arm_req      = 1'b0;
        mem_we       = 1'b0;

        if (dump_valid_q) begin
            dump_idx_d = (dump_idx_q == 5'd31) ? 5'd1 : dump_idx_q + 5'd1;
        end
        if (armed_q && stop_cnt_q != '0) begin
            stop_cnt_d = stop_cnt_q - 32'd1;
        end

        if (accept) begin
            if (mmio_hit) begin
                rdata_d = '0;
                if (data_mem_we) begin
                    if (strb_any) begin
                        case (mmio_sel)
                            3'd0: arm_req = 1'b1;
                            3'd2: begin
                                if (trap_cnt_q != 8'hFF) trap_cnt_d = trap_cnt_q + 8'd1;
                                arm_req = STOP_ON_TRAP;
                            end
                            3'd4: begin
                                if (!armed_q) begin
                                    dump_valid_d = 1'b1;
                                    dump_data_d  = data_mem_wdata;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    case (mmio_sel)
                        3'd0:    rdata_d = {31'd0, armed_q};
                        3'd2:    rdata_d = {24'd0, trap_cnt_q};
                        3'd4:    rdata_d = {27'd0, dump_idx_q};
                        default: rdata_d = '0;
                    endcase
                end
            end else if (sram_hit) begin
                rdata_d     = '0;
                mem_we      = data_mem_we;
                resp_sram_d = !data_mem_we;
            end else begin
                err_d   = 1'b1;
                rdata_d = data_mem_we ? 32'd0 : UNMAPPED_DATA;
            end
        end

        if (arm_req && !armed_q) begin
            armed_d    = 1'b1;
            stop_cnt_d = STOP_CNT_INIT;
        end
        done_d = done_q | (armed_d & (stop_cnt_d == '0));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            rdata_q      <= '0;
            resp_sram_q  <= 1'b0;
            err_q        <= 1'b0;
            armed_q      <= 1'b0;
            stop_cnt_q   <= '0;
            done_q       <= 1'b0;
            trap_cnt_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= 5'd1;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            rdata_q      <= rdata_d;
            resp_sram_q  <= resp_sram_d;
            err_q        <= err_d;
            armed_q      <= armed_d;
            stop_cnt_q   <= stop_cnt_d;
            done_q       <= done_d;
            trap_cnt_q   <= trap_cnt_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // NOTE: storage has no reset so it maps onto block RAM; the read port is registered.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mem_strb[b]) mem_q[mem_idx][8*b +: 8] <= data_mem_wdata[8*b +: 8];
            end
        end
        mem_rdata_q <= mem_q[mem_idx];
    end

    assign data_mem_rdata = resp_sram_q ? mem_rdata_q : rdata_q;
    assign rvalid_o       = (state_q == ST_RESP);
    assign err_o          = err_q;
    assign dump_valid_o   = dump_valid_q;
    assign dump_idx_o     = dump_idx_q;
    assign dump_data_o    = dump_data_q;
    assign trap_count_o   = trap_cnt_q;
    assign done_o         = done_q;

endmodule
